apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB requester. Turns a simple valid/ready command stream from the system side into
//  APB setup/access transfers toward the GPIO and UART slave interfaces.
//  Decodes the target slave from the address, waits on PREADY with a timeout, and
//  returns read data and error status on a held response port.
// PARAMETERS
//  ADDR_W        32     APB address width
//  DATA_W        32     APB data width
//  SEL_BIT       8      address bit selecting slave: 0 -> PSEL=2'b01 (GPIO), 1 -> PSEL=2'b10 (UART)
//  TIMEOUT       16     max ACCESS cycles waiting for PREADY before abort (>=1)
//  PROT          3'b000 constant driven on PPROT
// PORTS
//  PCLK       in   1       clock
//  PRESET     in   1       synchronous reset, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready at PCLK edge
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  transfer address
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       response present, held until rsp_ready
//  rsp_ready  in   1       response consumed
//  rsp_rdata  out  DATA_W  read data (0 for writes and for errors)
//  rsp_err    out  1       PSLVERR seen or timeout
//  PADDR      out  ADDR_W  APB address
//  PWDATA     out  DATA_W  APB write data
//  PWRITE     out  1       APB direction
//  PSEL       out  2       one-hot slave select
//  PENABLE    out  1       APB access phase
//  PPROT      out  3       = PROT
//  PRDATA     in   DATA_W  slave read data
//  PREADY     in   1       slave ready
//  PSLVERR    in   1       slave error, sampled only with PREADY in ACCESS
// BEHAVIOUR
//  Reset (PRESET=1 at an edge): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0,
//   cmd_ready=0 during reset and 1 in IDLE after, rsp_valid=0, rsp_rdata=0, rsp_err=0, timer=0.
//   Reset mid-transfer drops PSEL/PENABLE at that edge and discards the pending response.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On accept, register addr/wdata/write onto PADDR/PWDATA/PWRITE. -> SETUP.
//   SETUP: PSEL = one-hot per cmd_addr[SEL_BIT], PENABLE=0. One cycle. -> ACCESS.
//   ACCESS: PSEL held, PENABLE=1, PADDR/PWDATA/PWRITE stable. Timer increments each cycle.
//    PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR (rdata forced 0 if err).
//    Then PSEL=0, PENABLE=0, rsp_valid=1 next cycle. -> RESP.
//    Timer reaches TIMEOUT with PREADY still 0: abort with rsp_err=1, rsp_rdata=0. -> RESP.
//   RESP: rsp_valid=1, cmd_ready=0. rsp_ready=1 -> rsp_valid=0, timer=0 -> IDLE.
//  Latency: accept at edge N, SETUP in cycle N+1, ACCESS in N+2.
//   Zero-wait PREADY gives rsp_valid from N+3. Minimum cmd-to-cmd spacing is 4 cycles.
//  Only one transfer is outstanding; cmd_ready is low in SETUP, ACCESS and RESP.
//  PSEL is never 2'b11. PENABLE is never 1 without PSEL.
//  A PREADY arriving in the same cycle the timer hits TIMEOUT counts as a normal completion
//   (PREADY wins).
//  PADDR, PWDATA and PWRITE hold their last values in IDLE and RESP.
// TESTING
//  1. Write addr=0x000 data=0xA5, PREADY tied 1 -> PSEL=01, PENABLE 1 cycle;
//     rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
//  2. Read addr=0x100, PRDATA=0x3C, PREADY after 3 wait cycles -> PSEL=10;
//     rsp_rdata=0x3C, rsp_valid at N+6.
//  3. Read with PREADY never high, TIMEOUT=16 -> abort after 16 ACCESS cycles;
//     rsp_err=1, rsp_rdata=0, PSEL=0.
//  4. PREADY=1 with PSLVERR=1 on a read, PRDATA=0xFF -> rsp_err=1, rsp_rdata=0.
//  5. Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp held stable, cmd_ready=0,
//     no new SETUP until rsp_ready=1.
//  6. Assert PRESET during ACCESS -> PSEL/PENABLE=0 at next edge, rsp_valid never rises,
//     cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB requester bus for apb_master_bridge.
// master: the bridge's side. slave: the system and peripheral side.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PWRITE;
    logic [1:0]        PSEL;
    logic              PENABLE;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into one APB setup/access transfer to GPIO or UART,
// with a PREADY timeout, and returns the result on a response port held until consumed.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_BIT = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                pwrite_q,    pwrite_d;
    logic [1:0]          psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [TimerW-1:0]   timer_q,     timer_d;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        timer_d     = timer_q;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    pwrite_d = bus.cmd_write;
                    psel_d   = bus.cmd_addr[SEL_BIT] ? 2'b10 : 2'b01;
                    timer_d  = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                timer_d = timer_q + TimerW'(1);
                // PREADY takes priority over a timeout landing on the same edge
                if (bus.PREADY) begin
                    psel_d      = 2'b00;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
                    state_d     = StResp;
                end else if (timer_d == TimerW'(TIMEOUT)) begin
                    psel_d      = 2'b00;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 2'b00;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PPROT     = PROT;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed corner cases plus random transfers,
// each checked cycle by cycle against a per-transfer expected timeline and result.
module tb_apb_master_bridge;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_BIT = 8;
    localparam int unsigned TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEL_BIT(SEL_BIT),
        .TIMEOUT(TIMEOUT),
        .PROT   (3'b000)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic quiet_bus();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
    endtask

    // One transfer. Called at a negedge; the slave answers after `waits` ACCESS cycles.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned waits, input logic [31:0] prdata,
                           input logic slverr, input int unsigned hold, input logic valid_in_hold);
        logic [1:0]  exp_psel;
        logic        timed_out;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int unsigned k_end;
        int unsigned guard;

        exp_psel  = addr[SEL_BIT] ? 2'b10 : 2'b01;
        timed_out = (waits >= TIMEOUT);
        k_end     = timed_out ? TIMEOUT - 1 : waits;
        exp_err   = timed_out || slverr;
        exp_rdata = (wr || exp_err) ? 32'd0 : prdata;

        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;

        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~addr;
        bus.cmd_wdata = ~wdata;
        bus.cmd_write = ~wr;
        check("setup_psel", 32'(bus.PSEL), 32'(exp_psel));
        check("setup_penable", 32'(bus.PENABLE), 32'd0);
        check("setup_paddr", bus.PADDR, addr);
        check("setup_pwdata", bus.PWDATA, wdata);
        check("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
        check("setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);

        for (int unsigned k = 0; k <= k_end; k++) begin
            @(negedge PCLK);
            check("access_psel", 32'(bus.PSEL), 32'(exp_psel));
            check("access_penable", 32'(bus.PENABLE), 32'd1);
            check("access_paddr", bus.PADDR, addr);
            check("access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            bus.PREADY  = (k == waits);
            bus.PRDATA  = (k == waits) ? prdata : $urandom;
            bus.PSLVERR = (k == waits) ? slverr : 1'($urandom);
        end

        @(negedge PCLK);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("resp_psel", 32'(bus.PSEL), 32'd0);
        check("resp_penable", 32'(bus.PENABLE), 32'd0);
        check("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);

        bus.cmd_valid = valid_in_hold;
        repeat (hold) begin
            @(negedge PCLK);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("hold_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_psel", 32'(bus.PSEL), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;

        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("done_paddr_held", bus.PADDR, addr);
        check("done_pwrite_held", 32'(bus.PWRITE), 32'(wr));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_psel"}, 32'(bus.PSEL), 32'd0);
        check({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        logic        wr;
        logic [31:0] addr;
        int unsigned waits;

        quiet_bus();
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        check_reset_state("reset");
        check("reset_pwrite", 32'(bus.PWRITE), 32'd0);
        check("reset_paddr", bus.PADDR, 32'd0);
        check("reset_pwdata", bus.PWDATA, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("pprot", 32'(bus.PPROT), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Directed corners
        run_txn(1'b1, 32'h000, 32'hA5, 0, 32'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h100, 32'h0, 3, 32'h3C, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h100, 32'h0, 40, 32'h77, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h004, 32'h0, TIMEOUT - 1, 32'h5A, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h104, 32'h0, 0, 32'hFF, 1'b1, 0, 1'b0);
        run_txn(1'b0, 32'h008, 32'h0, 2, 32'h1234, 1'b0, 5, 1'b1);

        // Random transfers
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            addr  = $urandom;
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4)
                                                : $urandom_range(0, 4);
            run_txn(wr, addr, $urandom, waits, $urandom, ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 3), 1'($urandom));
        end

        // Reset in the middle of ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h100;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check_reset_state("midreset");
        PRESET     = 1'b0;
        bus.PREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("after_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("after_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("after_reset_psel", 32'(bus.PSEL), 32'd0);
        end
        bus.PREADY = 1'b0;
        run_txn(1'b1, 32'h1F0, 32'hCAFE, 1, 32'h0, 1'b0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Structural bus rules, checked every cycle outside reset
    always @(negedge PCLK) begin
        if (PRESET === 1'b0) begin
            if (bus.PSEL == 2'b11) check("psel_onehot", 32'(bus.PSEL), 32'd0);
            if (bus.PENABLE && bus.PSEL == 2'b00) check("penable_without_psel", 32'd1, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
